retire_trace_checker: RTL and testbench

//  Synthesizable, parametrised retire-trace checker for MIPS cores (single-cycle, multi-cycle, pipelined).

---
 rtl/rtc_pkg.sv | 22 ++
 rtl/rtc_trace_ram.sv | 24 ++
 rtl/retire_trace_checker.sv | 194 +++++++++++++++++++
 tb/tb_retire_trace_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and default sizing for the retire-trace checker.
package rtc_pkg;

  localparam int unsigned RTC_ADDR_W  = 32;
  localparam int unsigned RTC_DATA_W  = 32;
  localparam int unsigned RTC_DEPTH   = 64;
  localparam int unsigned RTC_CNT_W   = 8;
  localparam int unsigned RTC_TIMEOUT = 256;

  typedef enum logic [1:0] {
    RTC_IDLE,
    RTC_RUN,
    RTC_DONE
  } rtc_state_t;

  typedef struct packed {
    logic [RTC_ADDR_W-1:0] pc;
    logic [RTC_DATA_W-1:0] data;
    logic                  dchk;
  } rtc_entry_t;

endpackage

// File: rtl/rtc_trace_ram.sv
// Expected-trace storage: synchronous write, asynchronous read so the checker compares every cycle.
module rtc_trace_ram
  import rtc_pkg::*;
#(
  parameter int unsigned DEPTH = RTC_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  rtc_entry_t       wentry,
  input  logic [IDX_W-1:0] raddr,
  output rtc_entry_t       rentry_c
);

  rtc_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wentry;
  end

  assign rentry_c = mem[raddr];

endmodule

// File: rtl/retire_trace_checker.sv
// Compares each retired instruction against a preloaded expected trace; counts mismatches and flags hangs.
// Optional first-mismatch capture ports are built when FIRST_ERR_CAPTURE_EN is defined.
module retire_trace_checker
  import rtc_pkg::*;
#(
  parameter int unsigned ADDR_W  = RTC_ADDR_W,
  parameter int unsigned DATA_W  = RTC_DATA_W,
  parameter int unsigned DEPTH   = RTC_DEPTH,
  parameter int unsigned IDX_W   = $clog2(DEPTH),
  parameter int unsigned CNT_W   = RTC_CNT_W,
  parameter int unsigned TIMEOUT = RTC_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_pc,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_dchk,
  input  logic [IDX_W:0]    exp_len,
  input  logic              start,
  input  logic              ret_valid,
  input  logic [ADDR_W-1:0] ret_pc,
  input  logic [DATA_W-1:0] ret_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [IDX_W:0]    ptr
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic              first_err_vld,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [ADDR_W-1:0] first_err_pc,
  output logic [DATA_W-1:0] first_err_data
`endif
);

  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned GAP_W = $clog2(TIMEOUT);

  rtc_state_t        state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  ptr_d;
  logic [CNT_W-1:0]  err_d;
  logic              busy_d, done_d, pass_d, timeout_d;
  logic [LEN_W-1:0]  len_clamp_c;
  logic [LEN_W-1:0]  ptr_inc_c;
  logic [CNT_W-1:0]  err_sat_c;
  logic              mismatch_c;
  logic              ram_we_c;
  rtc_entry_t        wentry_c;
  rtc_entry_t        rentry_c;

`ifdef FIRST_ERR_CAPTURE_EN
  logic              fe_vld_d;
  logic [IDX_W-1:0]  fe_idx_d;
  logic [ADDR_W-1:0] fe_pc_d;
  logic [DATA_W-1:0] fe_data_d;
`endif

  // Trace writes are locked out while a run is reading the table.
  assign ram_we_c      = exp_we && (state_q != RTC_RUN) && ({1'b0, exp_idx} < LEN_W'(DEPTH));
  assign wentry_c.pc   = RTC_ADDR_W'(exp_pc);
  assign wentry_c.data = RTC_DATA_W'(exp_data);
  assign wentry_c.dchk = exp_dchk;

  rtc_trace_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk      (clk),
    .we       (ram_we_c),
    .waddr    (exp_idx),
    .wentry   (wentry_c),
    .raddr    (ptr[IDX_W-1:0]),
    .rentry_c (rentry_c)
  );

  assign len_clamp_c = (exp_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : exp_len;
  assign ptr_inc_c   = ptr + LEN_W'(1);
  assign err_sat_c   = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
  assign mismatch_c  = (ret_pc != ADDR_W'(rentry_c.pc)) ||
                       (rentry_c.dchk && (ret_wdata != DATA_W'(rentry_c.data)));

  // Next-state and next-value logic for every register.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    len_d     = len_q;
    ptr_d     = ptr;
    err_d     = err_cnt;
    done_d    = done;
    pass_d    = pass;
    timeout_d = timeout;
`ifdef FIRST_ERR_CAPTURE_EN
    fe_vld_d  = first_err_vld;
    fe_idx_d  = first_err_idx;
    fe_pc_d   = first_err_pc;
    fe_data_d = first_err_data;
`endif
    case (state_q)
      RTC_IDLE, RTC_DONE: begin
        if (start) begin
          err_d     = '0;
          ptr_d     = '0;
          gap_d     = '0;
          timeout_d = 1'b0;
          len_d     = len_clamp_c;
`ifdef FIRST_ERR_CAPTURE_EN
          fe_vld_d  = 1'b0;
          fe_idx_d  = '0;
          fe_pc_d   = '0;
          fe_data_d = '0;
`endif
          if (len_clamp_c == '0) begin
            state_d = RTC_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = RTC_RUN;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      RTC_RUN: begin
        if (ret_valid) begin
          gap_d = '0;
          ptr_d = ptr_inc_c;
          if (mismatch_c) err_d = err_sat_c;
`ifdef FIRST_ERR_CAPTURE_EN
          if (mismatch_c && !first_err_vld) begin
            fe_vld_d  = 1'b1;
            fe_idx_d  = ptr[IDX_W-1:0];
            fe_pc_d   = ret_pc;
            fe_data_d = ret_wdata;
          end
`endif
          if (ptr_inc_c == len_q) begin
            state_d = RTC_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
          state_d   = RTC_DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          pass_d    = 1'b0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = RTC_IDLE;
    endcase
    busy_d = (state_d == RTC_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RTC_IDLE;
      gap_q   <= '0;
      len_q   <= '0;
      ptr     <= '0;
      err_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
      first_err_vld  <= 1'b0;
      first_err_idx  <= '0;
      first_err_pc   <= '0;
      first_err_data <= '0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      ptr     <= ptr_d;
      err_cnt <= err_d;
      busy    <= busy_d;
      done    <= done_d;
      pass    <= pass_d;
      timeout <= timeout_d;
`ifdef FIRST_ERR_CAPTURE_EN
      first_err_vld  <= fe_vld_d;
      first_err_idx  <= fe_idx_d;
      first_err_pc   <= fe_pc_d;
      first_err_data <= fe_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_retire_trace_checker.sv
// Directed self-checking bench for retire_trace_checker (DEPTH=512 to allow a 300-entry run, TIMEOUT=16).
module tb_retire_trace_checker;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 512;
  localparam int unsigned IDX_W   = 9;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              exp_we = 1'b0;
  logic [IDX_W-1:0]  exp_idx = '0;
  logic [ADDR_W-1:0] exp_pc = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_dchk = 1'b0;
  logic [IDX_W:0]    exp_len = '0;
  logic              start = 1'b0;
  logic              ret_valid = 1'b0;
  logic [ADDR_W-1:0] ret_pc = '0;
  logic [DATA_W-1:0] ret_wdata = '0;
  logic              busy, done, pass, timeout;
  logic [CNT_W-1:0]  err_cnt;
  logic [IDX_W:0]    ptr;
`ifdef FIRST_ERR_CAPTURE_EN
  logic              first_err_vld;
  logic [IDX_W-1:0]  first_err_idx;
  logic [ADDR_W-1:0] first_err_pc;
  logic [DATA_W-1:0] first_err_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tpc   [11];
  logic [31:0] tdata [11];
  logic        tdchk [11];

  retire_trace_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_pc(exp_pc), .exp_data(exp_data),
    .exp_dchk(exp_dchk), .exp_len(exp_len), .start(start),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_wdata(ret_wdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .ptr(ptr)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_vld(first_err_vld), .first_err_idx(first_err_idx),
    .first_err_pc(first_err_pc), .first_err_data(first_err_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] pc, input logic [31:0] data, input logic dchk);
    exp_we   = 1'b1;
    exp_idx  = IDX_W'(idx);
    exp_pc   = pc;
    exp_data = data;
    exp_dchk = dchk;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic start_run(input int len);
    exp_len = (IDX_W+1)'(len);
    start   = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] wdata);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_wdata = wdata;
    tick();
    ret_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Trace table; '-' entries hold 0 in the RAM but are retired with 0x5555 to prove they are not compared.
    tpc[0] = 32'd0;  tdata[0] = 32'd15;     tdchk[0] = 1'b1;
    tpc[1] = 32'd4;  tdata[1] = 32'd20;     tdchk[1] = 1'b1;
    tpc[2] = 32'd8;  tdata[2] = 32'd30;     tdchk[2] = 1'b1;
    tpc[3] = 32'd12; tdata[3] = 32'd10;     tdchk[3] = 1'b1;
    tpc[4] = 32'd16; tdata[4] = 32'd20;     tdchk[4] = 1'b1;
    tpc[5] = 32'd20; tdata[5] = 32'h5555;   tdchk[5] = 1'b0;
    tpc[6] = 32'd24; tdata[6] = 32'd30;     tdchk[6] = 1'b1;
    tpc[7] = 32'd28; tdata[7] = 32'd1;      tdchk[7] = 1'b1;
    tpc[8] = 32'd32; tdata[8] = 32'h5555;   tdchk[8] = 1'b0;
    tpc[9] = 32'd36; tdata[9] = 32'd30;     tdchk[9] = 1'b1;
    tpc[10] = 32'd40; tdata[10] = 32'h5555; tdchk[10] = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);

    for (int i = 0; i < 11; i++) load(i, tpc[i], tdchk[i] ? tdata[i] : 32'd0, tdchk[i]);

    // 1: all retires match, one per cycle
    start_run(11);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 11; i++) begin
      retire(tpc[i], tdata[i]);
      if (i == 9) check("t1_done_early", 32'(done), 32'd0);
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_cnt), 32'd0);
    check("t1_ptr", 32'(ptr), 32'd11);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: entry 2 retires with wrong data
    start_run(11);
    for (int i = 0; i < 11; i++) retire(tpc[i], (i == 2) ? 32'd31 : tdata[i]);
    check("t2_done", 32'(done), 32'd1);
    check("t2_err", 32'(err_cnt), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
`ifdef FIRST_ERR_CAPTURE_EN
    check("t2_fe_vld", 32'(first_err_vld), 32'd1);
    check("t2_fe_idx", 32'(first_err_idx), 32'd2);
    check("t2_fe_pc", first_err_pc, 32'd8);
    check("t2_fe_data", first_err_data, 32'd31);
`endif

    // 3: retire one cycle in three
    start_run(11);
    for (int i = 0; i < 11; i++) begin
      tick();
      tick();
      check($sformatf("t3_ptr_stall%0d", i), 32'(ptr), 32'(i));
      retire(tpc[i], tdata[i]);
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_pass", 32'(pass), 32'd1);
    check("t3_timeout", 32'(timeout), 32'd0);
    check("t3_err", 32'(err_cnt), 32'd0);

    // 4: retire entries 0..4 then stop
    start_run(11);
    for (int i = 0; i < 5; i++) retire(tpc[i], tdata[i]);
    for (int i = 0; i < 15; i++) tick();
    check("t4_timeout_early", 32'(timeout), 32'd0);
    check("t4_busy_early", 32'(busy), 32'd1);
    tick();
    check("t4_timeout", 32'(timeout), 32'd1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_pass", 32'(pass), 32'd0);
    check("t4_ptr", 32'(ptr), 32'd5);

    // 5a: zero-length run finishes immediately
    start_run(0);
    check("t5a_done", 32'(done), 32'd1);
    check("t5a_pass", 32'(pass), 32'd1);
    check("t5a_timeout", 32'(timeout), 32'd0);
    check("t5a_busy", 32'(busy), 32'd0);

    // 5b: start and trace write during RUN are ignored
    start_run(11);
    retire(tpc[0], tdata[0]);
    retire(tpc[1], tdata[1]);
    exp_we = 1'b1; exp_idx = IDX_W'(3); exp_pc = 32'd999; exp_data = 32'd7; exp_dchk = 1'b1;
    exp_len = '0; start = 1'b1;
    tick();
    exp_we = 1'b0; start = 1'b0;
    check("t5b_busy", 32'(busy), 32'd1);
    check("t5b_ptr", 32'(ptr), 32'd2);
    for (int i = 2; i < 11; i++) retire(tpc[i], tdata[i]);
    check("t5b_pass", 32'(pass), 32'd1);
    check("t5b_err", 32'(err_cnt), 32'd0);

    // 5c: 300 mismatching retires saturate the counter
    for (int i = 11; i < 300; i++) load(i, 32'h100 + 32'(i), 32'd0, 1'b0);
    start_run(300);
    for (int i = 0; i < 300; i++) retire(32'hDEAD_0000, 32'd0);
    check("t5c_err", 32'(err_cnt), 32'd255);
    check("t5c_done", 32'(done), 32'd1);
    check("t5c_pass", 32'(pass), 32'd0);
    check("t5c_ptr", 32'(ptr), 32'd300);

    // 6: reset mid-run, then rerun from entry 0 on the retained trace
    start_run(11);
    for (int i = 0; i < 3; i++) retire(tpc[i], 32'd77);
    check("t6_ptr_pre", 32'(ptr), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_pass", 32'(pass), 32'd0);
    check("t6_timeout", 32'(timeout), 32'd0);
    check("t6_err", 32'(err_cnt), 32'd0);
    check("t6_ptr", 32'(ptr), 32'd0);
    start_run(11);
    for (int i = 0; i < 11; i++) retire(tpc[i], tdata[i]);
    check("t6_done_rerun", 32'(done), 32'd1);
    check("t6_pass_rerun", 32'(pass), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
